// File: rtl/netlist_0_resp_capture.sv
// Response capture for netlist runs: compacts accepted response words into a MISR,
// accumulates a saturating output toggle count and compares the final signature to golden.
module netlist_0_resp_capture #(
   parameter int               WIDTH       = 62,
   parameter int               NUM_VECTORS = 1000,
   parameter logic [WIDTH-1:0] POLY        = 62'h3,
   parameter int               CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             resp_valid,
   input  logic [WIDTH-1:0] resp,
   input  logic [WIDTH-1:0] golden_sig,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature,
   output logic [15:0]      vec_count,
   output logic [CNT_W-1:0] toggle_count
);

   localparam int PC_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] prev_resp;
   logic [WIDTH-1:0] sig_next;
   logic [WIDTH-1:0] diff;
   logic [PC_W-1:0]  pop;
   logic [CNT_W:0]   tog_sum;
   logic [CNT_W-1:0] tog_next;
   logic             last_accept;

   always_comb begin
      sig_next = {signature[WIDTH-2:0], 1'b0} ^ (signature[WIDTH-1] ? POLY : '0) ^ resp;
      diff     = resp ^ prev_resp;
      pop      = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + PC_W'(diff[i]);
      end
      // One extra bit catches the carry so the count sticks at all-ones instead of wrapping.
      tog_sum     = {1'b0, toggle_count} + (CNT_W + 1)'(pop);
      tog_next    = tog_sum[CNT_W] ? '1 : tog_sum[CNT_W-1:0];
      last_accept = (vec_count == 16'(NUM_VECTORS - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         signature    <= '0;
         vec_count    <= '0;
         toggle_count <= '0;
         prev_resp    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state        <= CAPTURE;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  pass         <= 1'b0;
                  signature    <= '0;
                  vec_count    <= '0;
                  toggle_count <= '0;
                  prev_resp    <= '0;
               end
            end
            CAPTURE: begin
               if (resp_valid) begin
                  signature    <= sig_next;
                  toggle_count <= tog_next;
                  prev_resp    <= resp;
                  vec_count    <= vec_count + 16'd1;
                  if (last_accept) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (sig_next == golden_sig);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_netlist_0_resp_capture.sv
// Bench for netlist_0_resp_capture: four instances with different run lengths share the
// response stream; each has its own start so only the started one captures.
module tb_netlist_0_resp_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        resp_valid = 1'b0;
   logic [61:0] resp = '0;
   logic [61:0] golden_sig = '0;
   logic        start2 = 1'b0, start4 = 1'b0, startk = 1'b0, start8 = 1'b0;

   logic        busy2, done2, pass2, busy4, done4, pass4;
   logic        busyk, donek, passk, busy8, done8, pass8;
   logic [61:0] sig2, sig4, sigk, sig8;
   logic [15:0] vc2, vc4, vck, vc8;
   logic [31:0] tog2, tog4, togk;
   logic [7:0]  tog8;

   int tests = 0;
   int fails = 0;

   logic [61:0] vecs [1000];
   logic [61:0] q [$];
   logic [61:0] exp_sig;
   longint      exp_tog;

   always #5 clk = ~clk;

   netlist_0_resp_capture #(.NUM_VECTORS(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .resp_valid(resp_valid), .resp(resp),
      .golden_sig(golden_sig), .busy(busy2), .done(done2), .pass(pass2),
      .signature(sig2), .vec_count(vc2), .toggle_count(tog2));

   netlist_0_resp_capture #(.NUM_VECTORS(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .resp_valid(resp_valid), .resp(resp),
      .golden_sig(golden_sig), .busy(busy4), .done(done4), .pass(pass4),
      .signature(sig4), .vec_count(vc4), .toggle_count(tog4));

   netlist_0_resp_capture #(.NUM_VECTORS(1000)) u_dutk (
      .clk(clk), .rst(rst), .start(startk), .resp_valid(resp_valid), .resp(resp),
      .golden_sig(golden_sig), .busy(busyk), .done(donek), .pass(passk),
      .signature(sigk), .vec_count(vck), .toggle_count(togk));

   netlist_0_resp_capture #(.NUM_VECTORS(8), .CNT_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .resp_valid(resp_valid), .resp(resp),
      .golden_sig(golden_sig), .busy(busy8), .done(done8), .pass(pass8),
      .signature(sig8), .vec_count(vc8), .toggle_count(tog8));

   // Inputs set before step() are sampled at its edge; outputs are read 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [61:0] rnd62();
      return 62'({$urandom(), $urandom()});
   endfunction

   // Reference: MISR step from the shift/feedback/xor rule, toggles as total Hamming
   // distance over the response list (starting from 0), clamped to the counter maximum.
   task automatic model(input longint cap, output logic [61:0] s, output longint t);
      logic [61:0] prev;
      s = '0;
      t = 0;
      prev = '0;
      foreach (q[i]) begin
         s = ((s << 1) ^ (s[61] ? 62'h3 : 62'h0)) ^ q[i];
         t = t + $countones(q[i] ^ prev);
         prev = q[i];
      end
      if (t > cap) t = cap;
   endtask

   initial begin
      // Reset and idle
      repeat (3) step();
      rst = 1'b0;
      chk("rst_busy", 64'(busy2), 64'd0);
      chk("rst_done", 64'(done2), 64'd0);
      chk("rst_pass", 64'(pass2), 64'd0);
      chk("rst_sig", 64'(sig2), 64'd0);
      chk("rst_vc", 64'(vc2), 64'd0);
      chk("rst_tog", 64'(tog2), 64'd0);
      resp_valid = 1'b1;
      repeat (3) begin
         resp = rnd62();
         step();
      end
      resp_valid = 1'b0;
      chk("idle_sig", 64'(sig2), 64'd0);
      chk("idle_vc", 64'(vc2), 64'd0);
      chk("idle_tog", 64'(tog2), 64'd0);
      chk("idle_busy", 64'(busy2), 64'd0);

      // MISR basic
      golden_sig = 62'd2;
      start2 = 1'b1; step(); start2 = 1'b0;
      chk("basic_busy", 64'(busy2), 64'd1);
      resp_valid = 1'b1; resp = 62'd1; step();
      chk("basic_mid_done", 64'(done2), 64'd0);
      resp = 62'd0; step();
      resp_valid = 1'b0;
      chk("basic_sig", 64'(sig2), 64'd2);
      chk("basic_vc", 64'(vc2), 64'd2);
      chk("basic_tog", 64'(tog2), 64'd2);
      chk("basic_done", 64'(done2), 64'd1);
      chk("basic_pass", 64'(pass2), 64'd1);
      chk("basic_busy_fall", 64'(busy2), 64'd0);

      // Feedback path, restarted from DONE
      golden_sig = 62'd4;
      start2 = 1'b1; step(); start2 = 1'b0;
      chk("fb_restart_done", 64'(done2), 64'd0);
      chk("fb_restart_pass", 64'(pass2), 64'd0);
      chk("fb_restart_sig", 64'(sig2), 64'd0);
      resp_valid = 1'b1; resp = 62'd1 << 61; step();
      resp = 62'd0; step();
      resp_valid = 1'b0;
      chk("fb_sig", 64'(sig2), 64'd3);
      chk("fb_tog", 64'(tog2), 64'd2);
      chk("fb_done", 64'(done2), 64'd1);
      chk("fb_pass", 64'(pass2), 64'd0);

      // Gapped valid on the 4-vector instance
      q.delete();
      golden_sig = '0;
      start4 = 1'b1; step(); start4 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         resp_valid = (i % 2 == 0);
         resp = resp_valid ? ((i % 4 == 0) ? '1 : '0) : rnd62();
         if (resp_valid) q.push_back(resp);
         step();
         chk("gap_vc", 64'(vc4), 64'((i + 2) / 2));
         chk("gap_done", 64'(done4), 64'(i >= 6));
      end
      resp_valid = 1'b0;
      model(64'hffff_ffff, exp_sig, exp_tog);
      chk("gap_tog", 64'(tog4), 64'd248);
      chk("gap_tog_model", 64'(tog4), 64'(exp_tog));
      chk("gap_sig", 64'(sig4), 64'(exp_sig));

      // Abort mid-run, then a full 1000-vector run with random gaps
      startk = 1'b1; step(); startk = 1'b0;
      resp_valid = 1'b1;
      repeat (500) begin
         resp = rnd62();
         step();
      end
      chk("abort_pre_vc", 64'(vck), 64'd500);
      rst = 1'b1; step(); rst = 1'b0;
      resp_valid = 1'b0;
      chk("abort_busy", 64'(busyk), 64'd0);
      chk("abort_done", 64'(donek), 64'd0);
      chk("abort_sig", 64'(sigk), 64'd0);
      chk("abort_vc", 64'(vck), 64'd0);
      chk("abort_tog", 64'(togk), 64'd0);
      q.delete();
      foreach (vecs[i]) begin
         vecs[i] = rnd62();
         q.push_back(vecs[i]);
      end
      model(64'hffff_ffff, exp_sig, exp_tog);
      golden_sig = exp_sig;
      startk = 1'b1; step(); startk = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            resp_valid = 1'b0;
            resp = rnd62();
            step();
         end
         resp_valid = 1'b1;
         resp = vecs[i];
         step();
         if (i == 998) chk("run_done_early", 64'(donek), 64'd0);
      end
      resp_valid = 1'b0;
      chk("run_vc", 64'(vck), 64'd1000);
      chk("run_sig", 64'(sigk), 64'(exp_sig));
      chk("run_tog", 64'(togk), 64'(exp_tog));
      chk("run_done", 64'(donek), 64'd1);
      chk("run_pass", 64'(passk), 64'd1);

      // Restart from DONE with resp_valid held, then toggle saturation at 8 bits
      golden_sig = '0;
      start8 = 1'b1; step(); start8 = 1'b0;
      resp_valid = 1'b1;
      repeat (8) begin
         resp = rnd62();
         step();
      end
      chk("sat_first_done", 64'(done8), 64'd1);
      start8 = 1'b1; resp = '1; step(); start8 = 1'b0;
      chk("sat_restart_busy", 64'(busy8), 64'd1);
      chk("sat_restart_done", 64'(done8), 64'd0);
      chk("sat_restart_vc", 64'(vc8), 64'd0);
      chk("sat_restart_tog", 64'(tog8), 64'd0);
      chk("sat_restart_sig", 64'(sig8), 64'd0);
      q.delete();
      for (int i = 0; i < 8; i++) begin
         resp = (i % 2 == 0) ? '1 : '0;
         q.push_back(resp);
         step();
         if (i == 3) chk("sat_tog_248", 64'(tog8), 64'd248);
         if (i == 4) chk("sat_tog_255", 64'(tog8), 64'd255);
      end
      model(64'd255, exp_sig, exp_tog);
      chk("sat_tog_end", 64'(tog8), 64'(exp_tog));
      chk("sat_sig", 64'(sig8), 64'(exp_sig));
      chk("sat_done", 64'(done8), 64'd1);
      repeat (3) begin
         resp = rnd62();
         step();
      end
      resp_valid = 1'b0;
      chk("hold_vc", 64'(vc8), 64'd8);
      chk("hold_sig", 64'(sig8), 64'(exp_sig));
      chk("hold_tog", 64'(tog8), 64'd255);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
